// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the IF/DM memory port arbiter.
// Optional debug/loader port: define MEM_ARB_DEBUG_PORT_EN.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  // Who the read data arriving next cycle belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2,
    OWN_DBG  = 2'd3
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF, DM and RAM-side signals around the arbiter.
// slave  : the arbiter itself.
// master : the surrounding core + RAM that drive requests and read data.
// Optional debug/loader signals appear when MEM_ARB_DEBUG_PORT_EN is defined.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_arb_pkg::DATA_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

`ifdef MEM_ARB_DEBUG_PORT_EN
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
           dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata,
           dbg_gnt, dbg_rvalid, dbg_rdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
           dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata,
           dbg_gnt, dbg_rvalid, dbg_rdata
  );
`else
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
`endif

endinterface

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Counts consecutive DM grants taken while IF is waiting; at_limit forces
// the next contended grant to IF. STARVE_LIMIT=0 removes the guard.
module mem_arb_starve_cnt #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  if (STARVE_LIMIT == 0) begin : g_off
    logic unused_in;
    assign unused_in = ^{clk, rst, inc, clr};
    assign at_limit  = 1'b0;
  end else begin : g_on
    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] cnt;

    // Saturating count; holds when neither inc nor clr (e.g. debug grants)
    always_ff @(posedge clk) begin
      if (rst || clr) begin
        cnt <= '0;
      end else if (inc && (cnt != CW'(STARVE_LIMIT))) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign at_limit = (cnt == CW'(STARVE_LIMIT));
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch (IF) and data (DM).
// DM has priority; a starvation counter forces IF through after
// STARVE_LIMIT consecutive contended DM grants. Read data returns one
// cycle after the grant and is steered to the recorded owner.
// Optional debug/loader port with absolute priority: MEM_ARB_DEBUG_PORT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = mem_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W       = mem_arb_pkg::DATA_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  logic              if_win;
  logic              dm_win;
  logic              dbg_win;
  logic              at_limit;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              if_rv;
  logic              dm_rv;
  owner_e            owner;

  // Pick one winner per cycle and steer its address/data onto the RAM bus
  always_comb begin
    dbg_win   = 1'b0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
`ifdef MEM_ARB_DEBUG_PORT_EN
    dbg_win   = !rst && bus.dbg_req;
`endif
    dm_win = !rst && !dbg_win && bus.dm_req && !(bus.if_req && at_limit);
    if_win = !rst && !dbg_win && bus.if_req && !dm_win;
`ifdef MEM_ARB_DEBUG_PORT_EN
    if (dbg_win) begin
      sel_we    = bus.dbg_we;
      sel_addr  = bus.dbg_addr;
      sel_wdata = bus.dbg_wdata;
    end else
`endif
    if (dm_win) begin
      sel_we    = bus.dm_we;
      sel_addr  = bus.dm_addr;
      sel_wdata = bus.dm_wdata;
    end else if (if_win) begin
      sel_addr  = bus.if_addr;
    end
  end

  // Debug grants neither bump nor clear the count, so IF's credit is kept
  mem_arb_starve_cnt #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .inc     (dm_win && bus.if_req),
    .clr     (!dbg_win && (if_win || !bus.if_req)),
    .at_limit(at_limit)
  );

  // Remember which requester owns the read data returning next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      owner <= OWN_NONE;
`ifdef MEM_ARB_DEBUG_PORT_EN
    end else if (dbg_win && !bus.dbg_we) begin
      owner <= OWN_DBG;
`endif
    end else if (dm_win && !bus.dm_we) begin
      owner <= OWN_DM;
    end else if (if_win) begin
      owner <= OWN_IF;
    end else begin
      owner <= OWN_NONE;
    end
  end

  // A read in flight when rst arrives is dropped rather than delivered
  assign if_rv = !rst && (owner == OWN_IF);
  assign dm_rv = !rst && (owner == OWN_DM);

  assign bus.if_gnt    = if_win;
  assign bus.dm_gnt    = dm_win;
  assign bus.if_rvalid = if_rv;
  assign bus.dm_rvalid = dm_rv;
  assign bus.if_rdata  = if_rv ? bus.mem_rdata : '0;
  assign bus.dm_rdata  = dm_rv ? bus.mem_rdata : '0;

  assign bus.mem_en    = if_win || dm_win || dbg_win;
  assign bus.mem_we    = sel_we;
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;

`ifdef MEM_ARB_DEBUG_PORT_EN
  assign bus.dbg_gnt    = dbg_win;
  assign bus.dbg_rvalid = !rst && (owner == OWN_DBG);
  assign bus.dbg_rdata  = bus.dbg_rvalid ? bus.mem_rdata : '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized IF/DM traffic against a behavioural model of the arbitration
// rules and memory contents. Debug-port scenario runs only when
// MEM_ARB_DEBUG_PORT_EN is defined.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned LIM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   g0_if  = 0;
  int   g0_dm  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus0 ();

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(LIM)) u_dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );

  // RAM: unwritten words read as {C3, low address byte}
  logic [15:0] ram   [0:255];
  bit          ram_w [0:255];
  logic [15:0] ram_q = '0;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        ram[bus.mem_addr[7:0]]   <= bus.mem_wdata;
        ram_w[bus.mem_addr[7:0]] <= 1'b1;
      end else begin
        ram_q <= ram_w[bus.mem_addr[7:0]] ? ram[bus.mem_addr[7:0]]
                                          : {8'hC3, bus.mem_addr[7:0]};
      end
    end
  end

  assign bus.mem_rdata  = ram_q;
  assign bus0.mem_rdata = 16'h0000;

  // Reference model state
  logic [15:0] shadow   [0:255];
  bit          shadow_w [0:255];
  int unsigned starve    = 0;
  bit          nx_if_v   = 1'b0;
  bit          nx_dm_v   = 1'b0;
  logic [15:0] nx_data   = '0;
  bit          last_if_g = 1'b0;
  bit          last_dm_g = 1'b0;

  function automatic logic [15:0] memval(input logic [15:0] a);
    return shadow_w[a[7:0]] ? shadow[a[7:0]] : {8'hC3, a[7:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called just after a negedge with inputs set; checks this cycle, advances the model
  task automatic tick();
    bit          e_if, e_dm, e_we, ev;
    logic [15:0] e_addr, e_wdata;
    #1;
    ev = nx_if_v && !rst;
    check("if_rvalid", bus.if_rvalid, ev);
    check("if_rdata", bus.if_rdata, ev ? nx_data : 16'h0);
    ev = nx_dm_v && !rst;
    check("dm_rvalid", bus.dm_rvalid, ev);
    check("dm_rdata", bus.dm_rdata, ev ? nx_data : 16'h0);

    e_if = 1'b0;
    e_dm = 1'b0;
    if (!rst) begin
      if (bus.if_req && bus.dm_req) begin
        if (LIM != 0 && starve == LIM) e_if = 1'b1;
        else                           e_dm = 1'b1;
      end else begin
        e_if = bus.if_req;
        e_dm = bus.dm_req;
      end
    end
    e_we    = e_dm && bus.dm_we;
    e_addr  = e_dm ? bus.dm_addr : (e_if ? bus.if_addr : 16'h0);
    e_wdata = e_dm ? bus.dm_wdata : 16'h0;

    check("if_gnt", bus.if_gnt, e_if);
    check("dm_gnt", bus.dm_gnt, e_dm);
    check("mem_en", bus.mem_en, e_if || e_dm);
    check("mem_we", bus.mem_we, e_we);
    check("mem_addr", bus.mem_addr, e_addr);
    check("mem_wdata", bus.mem_wdata, e_wdata);

    nx_if_v = e_if;
    nx_dm_v = e_dm && !bus.dm_we;
    if (e_if)         nx_data = memval(bus.if_addr);
    else if (nx_dm_v) nx_data = memval(bus.dm_addr);
    if (e_we) begin
      shadow[bus.dm_addr[7:0]]   = bus.dm_wdata;
      shadow_w[bus.dm_addr[7:0]] = 1'b1;
    end
    if (rst || !bus.if_req || e_if) starve = 0;
    else if (e_dm && starve < LIM)  starve++;

    last_if_g = bus.if_gnt;
    last_dm_g = bus.dm_gnt;
    @(negedge clk);
  endtask

  // Requesters hold until granted, then randomly issue a new request or idle
  task automatic drive(input int unsigned p_if, input int unsigned p_dm);
    if (!bus.if_req || last_if_g) begin
      bus.if_req  = ($urandom_range(99) < p_if);
      bus.if_addr = 16'($urandom_range(255));
    end
    if (!bus.dm_req || last_dm_g) begin
      bus.dm_req   = ($urandom_range(99) < p_dm);
      bus.dm_we    = 1'($urandom_range(1));
      bus.dm_addr  = 16'($urandom_range(255));
      bus.dm_wdata = 16'($urandom);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.if_req = 1'b0;  bus.if_addr = '0;
    bus.dm_req = 1'b0;  bus.dm_we = 1'b0;  bus.dm_addr = '0;  bus.dm_wdata = '0;
    bus0.if_req = 1'b0; bus0.if_addr = '0;
    bus0.dm_req = 1'b0; bus0.dm_we = 1'b0; bus0.dm_addr = '0; bus0.dm_wdata = '0;
`ifdef MEM_ARB_DEBUG_PORT_EN
    bus.dbg_req = 1'b0;  bus.dbg_we = 1'b0;  bus.dbg_addr = '0;  bus.dbg_wdata = '0;
    bus0.dbg_req = 1'b0; bus0.dbg_we = 1'b0; bus0.dbg_addr = '0; bus0.dbg_wdata = '0;
`endif
    rst = 1'b1;
    @(negedge clk);

    // Reset: requests high but nothing granted, no strobes, no rvalid
    bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    bus.dm_req = 1'b1; bus.dm_addr = 16'h0020;
    tick();
    tick();
    rst = 1'b0;
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    tick();

    // Load 0xA5A5 at 0x10, then IF-only read of it
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 16'h0010; bus.dm_wdata = 16'hA5A5;
    tick();
    bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    tick();
    check("ifonly_rvalid", bus.if_rvalid, 1'b1);
    check("ifonly_rdata", bus.if_rdata, 16'hA5A5);
    check("ifonly_dm_rvalid", bus.dm_rvalid, 1'b0);
    bus.if_req = 1'b0;
    tick();

    // DM write then read back
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 16'h0020; bus.dm_wdata = 16'h1234;
    tick();
    check("dmwr_no_rvalid", bus.dm_rvalid, 1'b0);
    bus.dm_we = 1'b0;
    tick();
    check("dmrd_rvalid", bus.dm_rvalid, 1'b1);
    check("dmrd_rdata", bus.dm_rdata, 16'h1234);
    bus.dm_req = 1'b0;
    tick();

    // Contention: 4 DM grants then 1 IF grant, repeating
    bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'h0020;
    for (int k = 0; k < 15; k++) begin
      tick();
      check("starve_pattern", last_if_g, (k % 5) == 4);
    end
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    tick();

    // Reset arriving the cycle after an IF read grant
    bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    tick();
    bus.if_req = 1'b0;
    rst = 1'b1;
    tick();
    check("rstmid_rvalid", bus.if_rvalid, 1'b0);
    check("rstmid_mem_en", bus.mem_en, 1'b0);
    rst = 1'b0;
    tick();
    bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    tick();
    check("postrst_rvalid", bus.if_rvalid, 1'b1);
    check("postrst_rdata", bus.if_rdata, 16'hA5A5);
    bus.if_req = 1'b0;
    tick();

    // Reset clears a partially built starvation count
    bus.if_req = 1'b1; bus.dm_req = 1'b1; bus.dm_we = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rst_clears_cnt", last_if_g, k == 4);
    end
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    tick();

    // Randomized traffic with occasional resets
    last_if_g = 1'b0;
    last_dm_g = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(199) == 0);
      if (n < 1000)      drive(30, 70);
      else if (n < 2000) drive(70, 50);
      else               drive(95, 95);
      tick();
    end
    rst = 1'b0;
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    tick();

    // STARVE_LIMIT=0: pure fixed priority, IF never gets in
    bus0.if_req = 1'b1; bus0.if_addr = 16'h0004;
    bus0.dm_req = 1'b1; bus0.dm_we = 1'b0; bus0.dm_addr = 16'h0008;
    for (int k = 0; k < 10; k++) begin
      #1;
      g0_if += int'(bus0.if_gnt);
      g0_dm += int'(bus0.dm_gnt);
      @(negedge clk);
    end
    check("lim0_dm_gnts", g0_dm, 10);
    check("lim0_if_gnts", g0_if, 0);
    bus0.if_req = 1'b0; bus0.dm_req = 1'b0;

`ifdef MEM_ARB_DEBUG_PORT_EN
    // Debug wins over both, and the count of 3 is preserved across it
    bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'h0020;
    repeat (3) tick();
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 16'h0010;
    #1;
    check("dbg_gnt", bus.dbg_gnt, 1'b1);
    check("dbg_blocks_dm", bus.dm_gnt, 1'b0);
    check("dbg_blocks_if", bus.if_gnt, 1'b0);
    @(negedge clk);
    bus.dbg_req = 1'b0;
    #1;
    check("dbg_rvalid", bus.dbg_rvalid, 1'b1);
    check("dbg_rdata", bus.dbg_rdata, memval(16'h0010));
    check("dbg_then_dm", bus.dm_gnt, 1'b1);
    @(negedge clk);
    #1;
    check("dbg_cnt_held", bus.if_gnt, 1'b1);
    @(negedge clk);
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
